// File: rtl/digit_serial_mult_pkg.sv
// Shared definitions for the digit-serial multiplier: FSM state encoding and
// the width of the partial-product counter.
package digit_serial_mult_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  // Counter must index nd*nd partial products; keep at least one bit.
  function automatic int cnt_w(input int nd);
    return (nd * nd > 1) ? $clog2(nd * nd) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_mult_digit_mult.sv
// Combinational unsigned DIGITxDIGIT multiplier producing a full 2*DIGIT-bit product.
module digit_mult #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0]   a,
  input  logic [DIGIT-1:0]   b,
  output logic [2*DIGIT-1:0] p
);

  assign p = {{DIGIT{1'b0}}, a} * {{DIGIT{1'b0}}, b};

endmodule

// File: rtl/digit_serial_mult.sv
// Unsigned WIDTHxWIDTH multiplier: one digit product per cycle is shifted into
// place and accumulated into out, with optional multiply-accumulate.
module digit_serial_mult
  import digit_serial_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               acc_en,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int ND = WIDTH / DIGIT;
  localparam int NN = ND * ND;
  localparam int CW = cnt_w(ND);
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int SW = $clog2(2 * WIDTH) + 1;
  localparam logic [CW-1:0] ND_C = CW'(ND);
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
    $error("digit_serial_mult: WIDTH must be a positive multiple of DIGIT");
  end

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  logic [DIGIT-1:0]   a_digs [ND];
  logic [DIGIT-1:0]   b_digs [ND];
  logic [IW-1:0]      i_idx, j_idx;
  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [2*DIGIT-1:0] prod;
  logic [SW-1:0]      sh;
  logic [2*WIDTH-1:0] pp_sh;

  for (genvar g = 0; g < ND; g++) begin : g_dig
    assign a_digs[g] = a_q[g*DIGIT +: DIGIT];
    assign b_digs[g] = b_q[g*DIGIT +: DIGIT];
  end

  // cnt walks A digits in the outer loop and B digits in the inner loop.
  assign i_idx = IW'(cnt_q / ND_C);
  assign j_idx = IW'(cnt_q % ND_C);
  assign a_dig = a_digs[i_idx];
  assign b_dig = b_digs[j_idx];

  digit_mult #(.DIGIT(DIGIT)) u_digit_mult (
    .a (a_dig),
    .b (b_dig),
    .p (prod)
  );

  assign sh    = SW'(DIGIT) * (SW'(i_idx) + SW'(j_idx));
  assign pp_sh = (2*WIDTH)'(prod) << sh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          out_d   = acc_en ? out_q : '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        out_d = out_q + pp_sh;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_digit_serial_mult.sv
// Directed bench for digit_serial_mult: an 8/2 instance for the main scenarios
// and a 4/2 instance for the short-latency case.
module tb_digit_serial_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, acc_en = 1'b0;
  logic [7:0]  in1 = '0, in2 = '0;
  logic        busy, done;
  logic [15:0] out;
  logic        start4 = 1'b0, acc4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  out4;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_serial_mult #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out)
  );

  digit_serial_mult #(.WIDTH(4), .DIGIT(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .acc_en(acc4),
    .in1(a4), .in2(b4), .busy(busy4), .done(done4), .out(out4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation on dut8 and wait for done; edges counts rising edges
  // from the accepting edge up to the one that raises done (40 = timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic acc,
                        output int edges);
    @(negedge clk);
    start = 1'b1; in1 = a; in2 = b; acc_en = acc;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int          e, dc, bc, t1, t2;
    logic [15:0] model, got;
    logic [7:0]  ra, rb;
    logic        racc;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_out4", 32'(out4), 0);
    @(negedge clk); rst = 1'b1;

    run_op(8'd255, 8'd255, 1'b0, e);
    chk("max_lat", 32'(e), 16);
    chk("max_out", 32'(out), 65025);
    @(posedge clk); #1;
    chk("done_clear", 32'(done), 0);
    chk("out_hold", 32'(out), 65025);

    run_op(8'd0, 8'd77, 1'b0, e);
    chk("zero_out", 32'(out), 0);

    run_op(8'd3, 8'd4, 1'b0, e);
    chk("mac_first", 32'(out), 12);
    run_op(8'd5, 8'd6, 1'b1, e);
    chk("mac_second", 32'(out), 42);

    run_op(8'd255, 8'd255, 1'b0, e);
    run_op(8'd255, 8'd255, 1'b1, e);
    chk("mac_wrap", 32'(out), 64514);

    // start pulsed mid-operation with new operands is ignored
    @(negedge clk);
    start = 1'b1; in1 = 8'd6; in2 = 8'd7; acc_en = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; in1 = 8'd9; in2 = 8'd9;
    @(negedge clk); start = 1'b0;
    dc = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    chk("ign_pulses", 32'(dc), 1);
    chk("ign_out", 32'(out), 42);

    // Asynchronous reset while cnt = 7
    @(negedge clk);
    start = 1'b1; in1 = 8'd200; in2 = 8'd100; acc_en = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_out", 32'(out), 0);
    @(negedge clk); rst = 1'b1;
    run_op(8'd13, 8'd11, 1'b0, e);
    chk("post_rst_lat", 32'(e), 16);
    chk("post_rst_out", 32'(out), 143);

    // Back-to-back: start held across done
    @(negedge clk);
    start = 1'b1; in1 = 8'd6; in2 = 8'd7; acc_en = 1'b0;
    @(posedge clk); #1;
    in1 = 8'd9; in2 = 8'd9;
    e = 0;
    while (!done && e < 40) begin @(posedge clk); #1; e++; end
    t1 = cyc;
    chk("b2b_first", 32'(out), 42);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    e = 0;
    while (!done && e < 40) begin @(posedge clk); #1; e++; end
    t2 = cyc;
    chk("b2b_second", 32'(out), 81);
    chk("b2b_gap", 32'(t2 - t1), 17);

    // Short configuration: 15*15, busy for exactly 4 cycles
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd15; acc4 = 1'b0;
    @(posedge clk); #1; start4 = 1'b0;
    bc = 0; e = 0; dc = 0;
    for (int k = 1; k <= 8; k++) begin
      if (busy4) bc++;
      @(posedge clk); #1;
      if (done4 && dc == 0) begin e = k; dc = 1; got = 16'(out4); end
    end
    chk("w4_lat", 32'(e), 4);
    chk("w4_out", 32'(got), 225);
    chk("w4_busy_cycles", 32'(bc), 4);

    // Pseudo-random operands against a behavioural reference
    model = out;
    for (int k = 0; k < 8; k++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      racc = 1'($urandom_range(0, 1));
      model = racc ? 16'(model + 16'(ra) * 16'(rb)) : 16'(16'(ra) * 16'(rb));
      run_op(ra, rb, racc, e);
      chk("rand_lat", 32'(e), 16);
      chk("rand_out", 32'(out), 32'(model));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
